// File: rtl/serial_tc_pkg.sv
// -----------------------------------------------------------------------------
// serial_tc_pkg
// Shared types and helpers for the bit-serial two's-complement word unit.
//   state_e   : FSM state encoding (IDLE, COPY, INVERT, PASS), 2 bits
//   cnt_width : width of the beat counter for a given word length
// -----------------------------------------------------------------------------
package serial_tc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COPY   = 2'd1,
      ST_INVERT = 2'd2,
      ST_PASS   = 2'd3
   } state_e;

   // Counter must hold beat indices 0..width-1.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_word_counter.sv
// -----------------------------------------------------------------------------
// serial_word_counter
// Beat counter for one serial word of WIDTH bits.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : a start-of-frame beat was accepted this cycle
//   inc       : a non-sof beat of the current word was accepted this cycle
//   last      : the beat being accepted now (if it is a non-sof beat) is the
//               MSB, i.e. beat index WIDTH-1
// cnt_q holds the index of the next expected beat. The sof beat is index 0
// itself, so a clear leaves the register at 1; finishing a word returns it
// to 0.
// -----------------------------------------------------------------------------
module serial_word_counter
   import serial_tc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam int CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = CNT_W'(1);
      end else if (inc) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: non-blocking assignments for flops so all registers update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serial_twos_comp_word.sv
// -----------------------------------------------------------------------------
// serial_twos_comp_word
// Bit-serial two's-complement unit for framed, LSB-first words of WIDTH bits.
// Each word is negated (neg=1) or passed (neg=0); the mode is taken on the
// start-of-frame beat. All outputs are registered, one cycle of latency.
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : input beat valid (low = stall, state holds)
//   in_sof     : input beat is the LSB of a new word (aborts any word in flight)
//   in_bit     : serial input data
//   neg        : 1 = negate, 0 = pass (sampled on valid sof beat)
//   out_valid  : output beat valid
//   out_sof    : first output bit of a word
//   out_eof    : last output bit (MSB) of a word
//   out_bit    : serial result
//   ovf        : with out_eof, negated word was the most-negative value
// Build option: define SERIAL_TC_OVF_EN to build overflow detection; without
// it ovf is tied to 0.
// Negation method: copy bits up to and including the first 1, invert the rest.
// -----------------------------------------------------------------------------
module serial_twos_comp_word
   import serial_tc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic in_valid,
   input  logic in_sof,
   input  logic in_bit,
   input  logic neg,
   output logic out_valid,
   output logic out_sof,
   output logic out_eof,
   output logic out_bit,
   output logic ovf
);

   state_e state_q, state_d;

   logic sof_beat;    // valid beat starting a new word
   logic word_beat;   // valid non-sof beat belonging to a word in flight
   logic cnt_last;
   logic eof_beat;

   logic out_valid_d, out_sof_d, out_eof_d, out_bit_d;

   assign sof_beat  = in_valid & in_sof;
   assign word_beat = in_valid & ~in_sof & (state_q != ST_IDLE);
   assign eof_beat  = word_beat & cnt_last;

   serial_word_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk  (clk),
      .rstn (rstn),
      .clr  (sof_beat),
      .inc  (word_beat),
      .last (cnt_last)
   );

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (sof_beat) begin
         if (neg) state_d = in_bit ? ST_INVERT : ST_COPY;
         else     state_d = ST_PASS;
      end else if (word_beat) begin
         if (cnt_last)                        state_d = ST_IDLE;
         else if (state_q == ST_COPY && in_bit) state_d = ST_INVERT;
      end
   end

   // Output logic (registered below). Non-sof beats in IDLE are dropped.
   always_comb begin
      out_valid_d = sof_beat | word_beat;
      out_sof_d   = sof_beat;
      out_eof_d   = eof_beat;
      out_bit_d   = 1'b0;
      if (sof_beat)       out_bit_d = in_bit;
      else if (word_beat) out_bit_d = (state_q == ST_INVERT) ? ~in_bit : in_bit;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_bit   <= 1'b0;
      end else begin
         out_valid <= out_valid_d;
         out_sof   <= out_sof_d;
         out_eof   <= out_eof_d;
         out_bit   <= out_bit_d;
      end
   end

`ifdef SERIAL_TC_OVF_EN
   // Still in COPY at the MSB with a 1 means the input was 100..0, whose
   // negation is not representable.
   logic ovf_d, ovf_q;

   assign ovf_d = eof_beat & (state_q == ST_COPY) & in_bit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
